max7219_spi_arbiter: RTL and testbench
======================================

MAX7219_SPI_ARBITER -- requirements
Module: max7219_spi_arbiter

Interface
REQ-001 Parameter CS_SETUP, default 4, clk cycles cs_n low before first byte start.
REQ-002 Parameter CS_HOLD, default 4, clk cycles cs_n held low after second byte avail.
REQ-003 Parameter GAP, default 8, clk cycles cs_n high between frames.
REQ-004 Parameter TIMEOUT, default 2^20-1, max clk cycles waiting for spi_avail per byte.
REQ-005 clk  in  1  system clock; all logic on posedge clk.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 req  in  2  per-requester frame request, level, held until matching ack.
REQ-008 word0  in  16  requester 0 frame, [15:8] register address, [7:0] data; stable while req[0]=1.
REQ-009 word1  in  16  requester 1 frame, same format.
REQ-010 ack  out  2  one-cycle pulse per requester, frame complete.
REQ-011 err  out  1  one-cycle pulse, frame aborted by timeout.
REQ-012 grant_id  out  1  requester currently or last served.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 cs_n  out  1  MAX7219 LOAD/CS, active low, framing all 16 bits.
REQ-015 spi_data_in  out  8  byte to byte-level SPI master.
REQ-016 spi_start  out  1  byte start request to SPI master.
REQ-017 spi_busy  in  1  SPI master busy.
REQ-018 spi_avail  in  1  SPI master one-cycle byte-done pulse.

Function
REQ-019 States: IDLE, SETUP, START_HI, WAIT_HI, START_LO, WAIT_LO, HOLD, DONE, GAP.
REQ-020 IDLE: if any req bit high, latch selected word into 16-bit frame register, update grant_id, go SETUP next cycle.
REQ-021 Arbitration round-robin: single request wins; both requesting -> requester != last grant_id wins.
REQ-022 SETUP: cs_n=0; counter counts CS_SETUP cycles, then START_HI.
REQ-023 START_HI: spi_data_in=frame[15:8]; spi_start=1 when spi_busy=0; go WAIT_HI same cycle start asserted.
REQ-024 WAIT_HI: spi_start held 1 until spi_busy seen high or spi_avail, then 0; on spi_avail go START_LO.
REQ-025 START_LO/WAIT_LO: identical handshake with frame[7:0]; on spi_avail go HOLD.
REQ-026 spi_data_in stable from start assertion until spi_avail.
REQ-027 HOLD: cs_n=0 for CS_HOLD cycles, then DONE.
REQ-028 DONE: cs_n=1; ack[grant_id]=1 for exactly one cycle; go GAP.
REQ-029 GAP: cs_n=1 for GAP cycles, then IDLE; requests during GAP wait.
REQ-030 cs_n low continuously from SETUP entry through HOLD exit (exactly one low window per frame).
REQ-031 Timeout counter cleared on entering WAIT_HI/WAIT_LO; reaching TIMEOUT -> spi_start=0, cs_n=1, err pulse one cycle, no ack, go GAP.
REQ-032 Timed-out requester's req remains pending; it competes again after GAP under round-robin.
REQ-033 Requester dropping req mid-frame: frame completes, ack still pulses.
REQ-034 spi_avail outside WAIT_HI/WAIT_LO ignored.
REQ-035 Counters saturate-free: width ceil(log2(param+1)), compare equality, no wrap.

Reset
REQ-036 reset=0 at posedge: state IDLE, cs_n=1, spi_start=0, spi_data_in=0, ack=0, err=0, busy=0, grant_id=1, counters 0.
REQ-037 Reset mid-frame: same values next edge; no ack or err emitted for aborted frame.

Verification
REQ-038 req=01, word0=16'h0C01, SPI model avail 20 cycles after start -> cs_n low 4+bytes+4 cycles, bytes 0x0C then 0x01, ack=01 pulse once.
REQ-039 req=11 held, words 16'h0101/16'h02FF -> frames served 0,1,0,1 alternating; GAP 8 cycles cs_n high between.
REQ-040 SPI model never asserts avail, TIMEOUT=100 -> err pulse at cycle 100 of WAIT_HI, cs_n=1, no ack, request retried.
REQ-041 reset=0 during WAIT_LO -> next edge cs_n=1, spi_start=0, busy=0, grant_id=1; no ack.
REQ-042 spi_busy held 1 in START_HI for 10 cycles -> spi_start stays 0 until busy drops, cs_n stays low.
REQ-043 req[0] dropped during WAIT_HI -> frame finishes, ack=01 pulses, arbiter returns IDLE.

Source files
------------

// File: rtl/max7219_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : max7219_spi_arbiter
// Description : Two-requester round-robin arbiter that frames 16-bit MAX7219
//               register writes as two byte transfers on a byte-level SPI
//               master. cs_n (LOAD) stays low for the whole frame. A stalled
//               SPI byte aborts the frame with an err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module max7219_spi_arbiter #(
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int GAP      = 8,
    parameter int TIMEOUT  = (1 << 20) - 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] word0,
    input  logic [15:0] word1,
    output logic [1:0]  ack,
    output logic        err,
    output logic        grant_id,
    output logic        busy,
    output logic        cs_n,
    output logic [7:0]  spi_data_in,
    output logic        spi_start,
    input  logic        spi_busy,
    input  logic        spi_avail
);

    // One phase counter serves SETUP, HOLD and GAP, so it is sized for the
    // largest of the three; the timeout counter is sized for TIMEOUT alone.
    localparam int c_phase_max = (CS_SETUP > CS_HOLD)
                               ? ((CS_SETUP > GAP) ? CS_SETUP : GAP)
                               : ((CS_HOLD  > GAP) ? CS_HOLD  : GAP);
    localparam int c_pw = $clog2(c_phase_max + 1);
    localparam int c_tw = $clog2(TIMEOUT + 1);

    localparam logic [c_pw-1:0] c_setup_last = c_pw'(CS_SETUP - 1);
    localparam logic [c_pw-1:0] c_hold_last  = c_pw'(CS_HOLD - 1);
    localparam logic [c_pw-1:0] c_gap_last   = c_pw'(GAP - 1);
    localparam logic [c_tw-1:0] c_to_last    = c_tw'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_SETUP    = 4'd1,
        S_START_HI = 4'd2,
        S_WAIT_HI  = 4'd3,
        S_START_LO = 4'd4,
        S_WAIT_LO  = 4'd5,
        S_HOLD     = 4'd6,
        S_DONE     = 4'd7,
        S_GAP      = 4'd8
    } state_t;

    state_t            r_state;
    logic [15:0]       r_frame;
    logic [c_pw-1:0]   r_pcnt;
    logic [c_tw-1:0]   r_tcnt;
    logic              w_pick;

    // Round-robin pick: a lone requester wins; on contention the requester
    // that was not served last wins.
    always_comb begin
        w_pick = req[1];
        if (req == 2'b11) begin
            w_pick = ~grant_id;
        end
    end

    // Frame sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_pcnt      <= '0;
            r_tcnt      <= '0;
            cs_n        <= 1'b1;
            spi_start   <= 1'b0;
            spi_data_in <= '0;
            ack         <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= 1'b1;
        end else begin
            ack <= '0;
            err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        grant_id <= w_pick;
                        r_frame  <= w_pick ? word1 : word0;
                        r_pcnt   <= '0;
                        cs_n     <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_pcnt == c_setup_last) begin
                        r_pcnt  <= '0;
                        r_state <= S_START_HI;
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end
                S_START_HI, S_START_LO: begin
                    // Byte is presented with the start request and held
                    // until the master reports it done.
                    spi_data_in <= (r_state == S_START_HI) ? r_frame[15:8] : r_frame[7:0];
                    if (!spi_busy) begin
                        spi_start <= 1'b1;
                        r_tcnt    <= '0;
                        r_state   <= (r_state == S_START_HI) ? S_WAIT_HI : S_WAIT_LO;
                    end
                end
                S_WAIT_HI, S_WAIT_LO: begin
                    if (spi_busy || spi_avail) begin
                        spi_start <= 1'b0;
                    end
                    if (spi_avail) begin
                        r_pcnt  <= '0;
                        r_state <= (r_state == S_WAIT_HI) ? S_START_LO : S_HOLD;
                    end else if (r_tcnt == c_to_last) begin
                        // Master never answered: abandon the frame, the
                        // request stays pending and competes again later.
                        spi_start <= 1'b0;
                        cs_n      <= 1'b1;
                        err       <= 1'b1;
                        r_pcnt    <= '0;
                        r_state   <= S_GAP;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_pcnt == c_hold_last) begin
                        cs_n    <= 1'b1;
                        ack     <= grant_id ? 2'b10 : 2'b01;
                        r_state <= S_DONE;
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_pcnt  <= '0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (r_pcnt == c_gap_last) begin
                        r_pcnt  <= '0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_max7219_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_max7219_spi_arbiter
// Description : Scoreboard bench for max7219_spi_arbiter with a byte-level
//               SPI master model (fixed latency, optional stall / dead mode).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max7219_spi_arbiter;

    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int GAP      = 8;
    localparam int TIMEOUT  = 100;
    localparam int LAT      = 20;
    // Low window: SETUP + per byte (START state + LAT+1 WAIT cycles) + HOLD = 52
    localparam int EXP_LOW    = CS_SETUP + 2 * (1 + LAT + 1) + CS_HOLD;
    // High between back-to-back frames: DONE + GAP + IDLE = 10
    localparam int EXP_HIGH   = 1 + GAP + 1;
    // Aborted frame: SETUP + START_HI + TIMEOUT WAIT cycles = 105
    localparam int EXP_TO_LOW = CS_SETUP + 1 + TIMEOUT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] word0 = 16'h0000;
    logic [15:0] word1 = 16'h0000;
    logic [1:0]  ack;
    logic        err;
    logic        grant_id;
    logic        busy;
    logic        cs_n;
    logic [7:0]  spi_data_in;
    logic        spi_start;
    logic        spi_busy;
    logic        spi_avail;

    logic m_busy = 1'b0, m_avail = 1'b0, m_dead = 1'b0, force_busy = 1'b0;
    int   m_cnt = 0;

    assign spi_busy  = m_busy | force_busy;
    assign spi_avail = m_avail;

    max7219_spi_arbiter #(
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .GAP      (GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .word0       (word0),
        .word1       (word1),
        .ack         (ack),
        .err         (err),
        .grant_id    (grant_id),
        .busy        (busy),
        .cs_n        (cs_n),
        .spi_data_in (spi_data_in),
        .spi_start   (spi_start),
        .spi_busy    (spi_busy),
        .spi_avail   (spi_avail)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI master model: avail pulses LAT cycles after spi_start is first seen high
    always @(posedge clk) begin
        m_avail <= 1'b0;
        if (m_busy) begin
            if (m_cnt == LAT - 1) begin
                m_busy  <= 1'b0;
                m_avail <= 1'b1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (spi_start && !m_dead) begin
            m_busy <= 1'b1;
            m_cnt  <= 1;
        end
    end

    typedef struct {
        bit          is_err;
        bit          id;
        logic [15:0] word;
        int          exp_low;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   acks_seen = 0;
    int   errs_seen = 0;
    int   starts_seen = 0;
    bit   gap_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: tracks the cs_n window and bytes, checks outputs against the scoreboard
    logic       prev_cs = 1'b1, prev_start = 1'b0, in_byte = 1'b0;
    logic [7:0] bytes [2];
    logic [7:0] held = 8'h00;
    int         nbytes = 0, low_len = 0, hi_len = -1, start_cyc = 0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_cs = 1'b1; prev_start = 1'b0; in_byte = 1'b0;
            nbytes = 0; low_len = 0; hi_len = -1;
        end else begin
            if (!cs_n) begin
                if (prev_cs) begin
                    if (gap_chk && hi_len >= 0) chk("cs_n high gap", hi_len, EXP_HIGH);
                    nbytes = 0;
                    low_len = 1;
                end else begin
                    low_len++;
                end
            end else begin
                if (!prev_cs) hi_len = 1;
                else if (hi_len >= 0) hi_len++;
            end
            if (spi_start && !prev_start) begin
                if (nbytes < 2) bytes[nbytes] = spi_data_in;
                nbytes++;
                starts_seen++;
                held = spi_data_in;
                in_byte = 1'b1;
                start_cyc = cyc;
            end
            if (spi_avail && in_byte) begin
                chk("spi_data_in stable", spi_data_in, held);
                in_byte = 1'b0;
            end
            if (ack != 2'b00 || err) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected output: ack=%b err=%b, nothing expected", ack, err);
                end else begin
                    e = sb.pop_front();
                    chk("output kind err", err, e.is_err);
                    chk("grant_id", grant_id, e.id);
                    if (!e.is_err) begin
                        chk("ack onehot", ack, e.id ? 32'd2 : 32'd1);
                        chk("byte count", nbytes, 2);
                        chk("frame bytes", {bytes[0], bytes[1]}, e.word);
                        if (e.exp_low != 0) chk("cs_n low window", low_len, e.exp_low);
                        acks_seen++;
                    end else begin
                        chk("err without ack", ack, 0);
                        chk("err cs_n high", cs_n, 1);
                        chk("err latency", cyc - start_cyc, TIMEOUT);
                        chk("err low window", low_len, e.exp_low);
                        chk("err first byte", bytes[0], e.word[15:8]);
                        errs_seen++;
                    end
                end
            end
            prev_cs = cs_n;
            prev_start = spi_start;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic wait_acks(input int n, input int budget);
        int k = 0;
        while (acks_seen < n && k < budget) begin tick(1); k++; end
        chk("ack arrival", acks_seen >= n, 1);
    endtask

    task automatic wait_errs(input int n, input int budget);
        int k = 0;
        while (errs_seen < n && k < budget) begin tick(1); k++; end
        chk("err arrival", errs_seen >= n, 1);
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (starts_seen < n && k < budget) begin tick(1); k++; end
        chk("start arrival", starts_seen >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin tick(1); k++; end
        chk("return to idle", busy, 0);
    endtask

    initial begin
        int base;
        int bad;
        // Reset values
        reset = 1'b0;
        tick(3);
        chk("rst cs_n", cs_n, 1);
        chk("rst spi_start", spi_start, 0);
        chk("rst spi_data_in", spi_data_in, 0);
        chk("rst ack", ack, 0);
        chk("rst err", err, 0);
        chk("rst busy", busy, 0);
        chk("rst grant_id", grant_id, 1);
        reset = 1'b1;
        tick(2);

        // Single frame from requester 0
        word0 = 16'h0C01;
        sb.push_back('{1'b0, 1'b0, 16'h0C01, EXP_LOW});
        req = 2'b01;
        wait_acks(1, 400);
        req = 2'b00;
        wait_idle(100);

        // Both requesting: alternate 0,1,0,1 from a fresh reset
        do_reset();
        word0 = 16'h0101;
        word1 = 16'h02FF;
        sb.push_back('{1'b0, 1'b0, 16'h0101, EXP_LOW});
        sb.push_back('{1'b0, 1'b1, 16'h02FF, EXP_LOW});
        sb.push_back('{1'b0, 1'b0, 16'h0101, EXP_LOW});
        sb.push_back('{1'b0, 1'b1, 16'h02FF, EXP_LOW});
        gap_chk = 1'b1;
        req = 2'b11;
        wait_acks(5, 1000);
        req = 2'b00;
        gap_chk = 1'b0;
        wait_idle(100);

        // Dead SPI master: timeout, then the same request is retried
        m_dead = 1'b1;
        word0 = 16'h0A55;
        sb.push_back('{1'b1, 1'b0, 16'h0A55, EXP_TO_LOW});
        sb.push_back('{1'b0, 1'b0, 16'h0A55, EXP_LOW});
        req = 2'b01;
        wait_errs(1, 400);
        m_dead = 1'b0;
        wait_acks(6, 400);
        req = 2'b00;
        wait_idle(100);

        // Reset while the second byte is in flight
        word1 = 16'h0A0B;
        base = starts_seen;
        req = 2'b10;
        wait_starts(base + 2, 400);
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("midrst cs_n", cs_n, 1);
        chk("midrst spi_start", spi_start, 0);
        chk("midrst busy", busy, 0);
        chk("midrst grant_id", grant_id, 1);
        chk("midrst ack", ack, 0);
        reset = 1'b1;
        req = 2'b00;
        tick(60);
        chk("no ack after reset abort", acks_seen, 6);

        // SPI master busy while waiting to start the first byte
        force_busy = 1'b1;
        word0 = 16'h0305;
        sb.push_back('{1'b0, 1'b0, 16'h0305, 0});
        req = 2'b01;
        bad = 0;
        for (int i = 0; i < CS_SETUP + 12; i++) begin
            tick(1);
            if (spi_start) bad++;
        end
        chk("start held off while busy", bad, 0);
        chk("cs_n low while busy", cs_n, 0);
        force_busy = 1'b0;
        wait_acks(7, 400);
        req = 2'b00;
        wait_idle(100);

        // Request dropped mid-frame still completes and acks
        word0 = 16'h0F00;
        sb.push_back('{1'b0, 1'b0, 16'h0F00, EXP_LOW});
        base = starts_seen;
        req = 2'b01;
        wait_starts(base + 1, 400);
        req = 2'b00;
        wait_acks(8, 400);
        wait_idle(100);
        tick(30);
        chk("idle after dropped req busy", busy, 0);
        chk("idle after dropped req cs_n", cs_n, 1);
        chk("ack total", acks_seen, 8);

        chk("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
